// File: rtl/irq_ctrl_if.sv
// Interrupt controller bus: event sources, mask port, CPU ack and dispatch outputs.
// The master drives sources, mask writes and ack; the slave is the controller.
interface irq_ctrl_if;
    logic [7:0] irq_src;
    logic       mask_we;
    logic [7:0] mask_d;
    logic       ack;
    logic [7:0] intmask;
    logic [7:0] pending;
    logic       intr;
    logic [2:0] vect;
    logic       busy;

    modport master (
        output irq_src, mask_we, mask_d, ack,
        input  intmask, pending, intr, vect, busy
    );

    modport slave (
        input  irq_src, mask_we, mask_d, ack,
        output intmask, pending, intr, vect, busy
    );
endinterface

// File: rtl/irq_ctrl.sv
// 7-source priority interrupt controller: pulse latched at edge E0, dispatched at E0+1 via intr toggle.
// One interrupt in service at a time; further events wait in pending until ack.
module irq_ctrl (
    input  logic        clock,
    input  logic        reset_n,
    irq_ctrl_if.slave   bus
);
    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t     state;
    logic [7:0] mask_q;
    logic [7:0] pend_q;
    logic       intr_q;
    logic [2:0] vect_q;

    logic [7:0] mask_nxt;
    logic [7:0] win_oh;
    logic [2:0] win_idx;
    logic       dispatch;
    logic [7:0] pend_nxt;

    always_comb begin
        mask_nxt = bus.mask_we ? {bus.mask_d[7:1], 1'b0} : mask_q;
        win_idx  = 3'd0;
        win_oh   = 8'h00;
        // Descending scan so the lowest-numbered pending source is the final assignment.
        for (int i = 7; i >= 1; i--) begin
            if (pend_q[i]) begin
                win_idx = 3'(i);
                win_oh  = 8'(1) << i;
            end
        end
        dispatch = (state == IDLE) && (pend_q != 8'h00);
        // New pulses override the dispatch clear; the post-write mask has the final word.
        pend_nxt = ((pend_q & ~(dispatch ? win_oh : 8'h00)) | (bus.irq_src & mask_nxt)) & mask_nxt;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            mask_q <= 8'h00;
            pend_q <= 8'h00;
            intr_q <= 1'b0;
            vect_q <= 3'd0;
        end else begin
            mask_q <= mask_nxt;
            pend_q <= pend_nxt;
            case (state)
                IDLE: begin
                    if (dispatch) begin
                        intr_q <= ~intr_q;
                        vect_q <= win_idx;
                        state  <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (bus.ack) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.intmask = mask_q;
    assign bus.pending = pend_q;
    assign bus.intr    = intr_q;
    assign bus.vect    = vect_q;
    assign bus.busy    = (state == ACTIVE);
endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: hand-computed expectations for dispatch, priority, masking and reset.
module tb_irq_ctrl;
    logic clock;
    logic reset_n;
    int   n_chk;
    int   n_pass;

    irq_ctrl_if bus ();

    irq_ctrl dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; inputs applied before the call are sampled there.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [7:0] pend, input logic intr,
                             input logic [2:0] vect, input logic busy);
        check({tag, ".pending"}, bus.pending, pend);
        check({tag, ".intr"},    {7'd0, bus.intr}, {7'd0, intr});
        check({tag, ".vect"},    {5'd0, bus.vect}, {5'd0, vect});
        check({tag, ".busy"},    {7'd0, bus.busy}, {7'd0, busy});
    endtask

    task automatic write_mask(input logic [7:0] m);
        bus.mask_we = 1'b1;
        bus.mask_d  = m;
        step();
        bus.mask_we = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] src);
        bus.irq_src = src;
        step();
        bus.irq_src = 8'h00;
    endtask

    task automatic do_ack();
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
    endtask

    initial begin
        n_chk       = 0;
        n_pass      = 0;
        reset_n     = 1'b0;
        bus.irq_src = 8'h00;
        bus.mask_we = 1'b0;
        bus.mask_d  = 8'h00;
        bus.ack     = 1'b0;
        step();
        step();
        check("rst.intmask", bus.intmask, 8'h00);
        check_out("rst", 8'h00, 1'b0, 3'd0, 1'b0);
        reset_n = 1'b1;
        step();

        // Basic latch-then-dispatch latency
        write_mask(8'h06);
        check("m06.intmask", bus.intmask, 8'h06);
        pulse(8'h02);
        check_out("lat.e0", 8'h02, 1'b0, 3'd0, 1'b0);
        step();
        check_out("lat.e1", 8'h00, 1'b1, 3'd1, 1'b1);
        do_ack();
        check_out("lat.ack", 8'h00, 1'b1, 3'd1, 1'b0);

        // Priority between two simultaneous sources; ack edge does not dispatch
        pulse(8'h06);
        check_out("pri.lat", 8'h06, 1'b1, 3'd1, 1'b0);
        step();
        check_out("pri.d1", 8'h04, 1'b0, 3'd1, 1'b1);
        do_ack();
        check_out("pri.ack", 8'h04, 1'b0, 3'd1, 1'b0);
        step();
        check_out("pri.d2", 8'h00, 1'b1, 3'd2, 1'b1);
        do_ack();

        // Coalescing while in service
        pulse(8'h02);
        step();
        check_out("coal.d", 8'h00, 1'b0, 3'd1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            pulse(8'h02);
            step();
        end
        check_out("coal.act", 8'h02, 1'b0, 3'd1, 1'b1);
        do_ack();
        check_out("coal.ack", 8'h02, 1'b0, 3'd1, 1'b0);
        step();
        check_out("coal.d2", 8'h00, 1'b1, 3'd1, 1'b1);
        do_ack();
        step();
        step();
        check_out("coal.once", 8'h00, 1'b1, 3'd1, 1'b0);

        // Pulse on the source being dispatched keeps it pending
        pulse(8'h02);
        pulse(8'h02);
        check_out("setwin.d", 8'h02, 1'b0, 3'd1, 1'b1);
        do_ack();
        step();
        check_out("setwin.d2", 8'h00, 1'b1, 3'd1, 1'b1);
        do_ack();

        // Masked source is discarded; mask write clears pending
        write_mask(8'h02);
        pulse(8'h04);
        check_out("msk.drop", 8'h00, 1'b1, 3'd1, 1'b0);
        step();
        check_out("msk.nodisp", 8'h00, 1'b1, 3'd1, 1'b0);
        pulse(8'h02);
        step();
        check_out("msk.act", 8'h00, 1'b0, 3'd1, 1'b1);
        pulse(8'h02);
        check("msk.pend02", bus.pending, 8'h02);
        write_mask(8'h00);
        check("msk.clr", bus.pending, 8'h00);
        check("msk.m00", bus.intmask, 8'h00);
        do_ack();
        step();
        check_out("msk.idle", 8'h00, 1'b0, 3'd1, 1'b0);

        // Mask clear and pulse on the same edge: new mask governs
        write_mask(8'h02);
        bus.irq_src = 8'h02;
        write_mask(8'h00);
        bus.irq_src = 8'h00;
        check_out("mskpulse", 8'h00, 1'b0, 3'd1, 1'b0);

        // Mask write on the dispatch edge: winner from the old pending/mask
        write_mask(8'h06);
        pulse(8'h04);
        write_mask(8'h00);
        check_out("mskdisp", 8'h00, 1'b1, 3'd2, 1'b1);
        check("mskdisp.m", bus.intmask, 8'h00);
        do_ack();

        // Source 0 is reserved
        bus.irq_src = 8'h01;
        write_mask(8'hFF);
        bus.irq_src = 8'h00;
        check("src0.intmask", bus.intmask, 8'hFE);
        pulse(8'h01);
        step();
        check_out("src0", 8'h00, 1'b1, 3'd2, 1'b0);

        // Reset mid-service
        pulse(8'h08);
        step();
        check_out("rsta.act", 8'h00, 1'b0, 3'd3, 1'b1);
        pulse(8'h10);
        check("rsta.pend", bus.pending, 8'h10);
        #2;
        reset_n = 1'b0;
        #1;
        check_out("rsta.async", 8'h00, 1'b0, 3'd0, 1'b0);
        check("rsta.intmask", bus.intmask, 8'h00);
        step();
        reset_n = 1'b1;
        do_ack();
        check_out("rsta.ack", 8'h00, 1'b0, 3'd0, 1'b0);
        step();
        step();
        check_out("rsta.quiet", 8'h00, 1'b0, 3'd0, 1'b0);
        write_mask(8'hFE);
        pulse(8'h10);
        step();
        check_out("rsta.fresh", 8'h00, 1'b1, 3'd4, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter: none; source count fixed at 8, vector width fixed at 3.
REQ-002 clock  in  1  system clock; all state changes on its rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 irq_src  in  8  event pulses, synchronous to clock; bit i = source i; bit 0 reserved and ignored.
REQ-005 mask_we  in  1  mask write strobe, one cycle.
REQ-006 mask_d  in  8  new mask value, taken when mask_we=1.
REQ-007 ack  in  1  end-of-interrupt strobe from the CPU port write, one cycle.
REQ-008 intmask  out  8  current mask register; bit 0 reads 0.
REQ-009 pending  out  8  latched, not-yet-dispatched events; bit 0 reads 0.
REQ-010 intr  out  1  toggle-style request to the core; each toggle = one new interrupt.
REQ-011 vect  out  3  number of the interrupt being serviced.
REQ-012 busy  out  1  1 while a dispatched interrupt awaits ack.

Function
REQ-013 Two states: IDLE (busy=0) and ACTIVE (busy=1).
REQ-014 Latching: at an edge where irq_src[i]=1 and intmask[i]=1 (i=1..7), pending[i] becomes 1; with intmask[i]=0 the pulse is discarded.
REQ-015 Coalescing: a pulse on a source already pending produces no additional dispatch.
REQ-016 Priority: lowest-numbered pending source wins (1 highest, 7 lowest).
REQ-017 Dispatch: in IDLE with pending!=0 at an edge, the block toggles intr, loads vect with the winning index, clears that pending bit and enters ACTIVE, all at the same edge.
REQ-018 Latency: pulse sampled at edge E0 gives pending set after E0 and dispatch at E0+1 when IDLE.
REQ-019 ACTIVE: intr and vect hold stable; pending keeps latching new events; no dispatch occurs.
REQ-020 ack in ACTIVE returns to IDLE at that edge; the next dispatch occurs no earlier than the following edge.
REQ-021 ack in IDLE is ignored, with no state change.
REQ-022 Mask write: intmask <= mask_d with bit 0 forced to 0; pending bits whose new mask bit is 0 are cleared at the same edge.
REQ-023 Simultaneous: a pulse on source i in the same edge as dispatch of source i leaves pending[i]=1, so the set wins over the dispatch clear.
REQ-024 Simultaneous: mask_we clearing bit i together with a pulse on source i leaves pending[i]=0, so the new mask governs.
REQ-025 Simultaneous: when mask_we occurs in the dispatch edge, the winner is chosen from pending and mask as they were before the edge.
REQ-026 Simultaneous ack and new pending in ACTIVE: return to IDLE only; dispatch occurs at the next edge.
REQ-027 vect retains its last value in IDLE.

Reset
REQ-028 reset_n=0 forces, asynchronously: state IDLE, busy=0, intr=0, vect=0, intmask=0, pending=0.
REQ-029 Reset during ACTIVE discards the in-service interrupt and all pending events; no intr toggle is generated by reset or its release.
REQ-030 The first dispatch after reset release requires a fresh unmasked pulse.

Verification
REQ-031 mask=8'h06, pulse src[1] at E0 -> pending=8'h02 after E0; intr 0->1, vect=1, busy=1, pending=0 after E0+1.
REQ-032 mask=8'h06, pulses src[2] and src[1] in the same cycle -> vect=1 first; ack -> busy=0; next edge -> intr toggles again, vect=2.
REQ-033 mask=8'h02, pulse src[2] -> pending stays 0 and intr never toggles; mask write 8'h00 with pending=8'h02 -> pending=0.
REQ-034 ACTIVE with vect=1; three pulses on src[1] -> pending=8'h02 only; after ack exactly one further dispatch of vect=1.
REQ-035 ACTIVE, reset_n low for 1 cycle mid-service -> all outputs 0 immediately; ack after release ignored; no toggle.
REQ-036 irq_src=8'h01 with mask_d=8'hFF -> intmask=8'hFE, pending[0]=0, no dispatch.
